ddr_maint_responder: RTL
========================

Name: ddr_maint_responder

Overview:
- Responder side of the controller-to-command-path maintenance handshake.
- Gates read/write traffic with rw_proc and reports quiescence on rw_idle.
- Captures refresh_rdy and mrs_update_rdy pulses and issues the DDR command sequences with timing enforced: PRECHARGE ALL then REFRESH, or PRECHARGE ALL then MRS.
- Sits between the controller FSM and the DDR command bus driver.

Parameters:
- MRS_WIDTH, 14, width of mrs_update_cmd and cmd_addr.
- T_RP, 11, clocks from PREA issue until the next command is allowed.
- T_RFC, 208, clocks from REF issue until done.
- T_MOD, 24, clocks from MRS issue until done.
- CNT_W, 9, timer width; must hold max(T_RP, T_RFC, T_MOD).

Ports:
- clock_t  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rw_proc  in  1  controller grant for read/write traffic.
- rw_busy  in  1  datapath has an outstanding burst.
- rw_req_valid  in  1  upstream R/W request.
- rw_req_ready  out  1  request accepted this cycle.
- rw_idle  out  1  no traffic in flight, traffic gated off.
- refresh_rdy  in  1  one-cycle refresh request pulse.
- mrs_update_rdy  in  1  one-cycle MRS update pulse.
- mrs_update_cmd  in  MRS_WIDTH  MR0 value; sampled with mrs_update_rdy.
- cmd_valid  out  1  one-cycle command strobe.
- cmd_code  out  2  0=NOP, 1=PREA, 2=REF, 3=MRS.
- cmd_addr  out  MRS_WIDTH  MRS payload; 0 for other commands.
- maint_busy  out  1  maintenance sequence active.
- err_proto  out  1  sticky protocol error.

Behaviour:
Reset:
- All outputs are 0, except rw_idle=1.
- State is S_RUN, pending flags and timer are cleared.
- Reset mid-sequence aborts the sequence immediately; no command is issued after reset deassertion until a new request arrives.

Gating:
- rw_req_ready = rw_proc & ~maint_busy & (state==S_RUN), combinational.
- rw_idle is registered: 1 on the cycle after any cycle where rw_proc=0, rw_busy=0 and no request was accepted; otherwise 0.

Request capture (evaluated every cycle, any state):
- refresh_rdy=1 sets ref_pend.
- mrs_update_rdy=1 sets mrs_pend and latches mrs_update_cmd into mrs_q.
- A pulse arriving while its own pend flag is already set sets err_proto; the pend flag stays 1 and mrs_q is overwritten by the newer value.
- err_proto clears only on reset.

FSM:
- S_RUN: if (ref_pend|mrs_pend) & rw_idle, go to S_PREA. Pending requests with rw_idle=0 wait; the bridge never forces a drain.
- S_PREA:
  - Issue cmd_valid=1, cmd_code=1 for one cycle.
  - Load timer=T_RP-1 and go to S_TRP.
  - maint_busy=1 from this cycle until return to S_RUN.
- S_TRP: decrement the timer. At 0, go to S_REF if ref_pend, else S_MRS. Refresh has priority when both are pending.
- S_REF: issue cmd_code=2, clear ref_pend, load timer=T_RFC-1, go to S_TRFC.
- S_MRS: issue cmd_code=3 with cmd_addr=mrs_q, clear mrs_pend, load timer=T_MOD-1, go to S_TMOD.
- S_TRFC / S_TMOD: decrement the timer. At 0:
  - If the other request is pending, go directly to its issue state (S_REF or S_MRS) without a second PREA.
  - Otherwise go to S_RUN.
- A pend clear in S_REF/S_MRS coinciding with a new pulse of the same type: the set wins and err_proto is not raised.

Command spacing:
- PREA to REF/MRS is exactly T_RP clocks.
- REF to next command is ≥ T_RFC clocks; MRS to next command is ≥ T_MOD clocks.

Protocol checks:
- rw_proc=1 while maint_busy=1 sets err_proto.
- rw_req_ready stays 0 regardless of rw_proc while maint_busy=1.

Optional Feature:
- Macro: DDR_MAINT_STATS_EN.
- Defined:
  - Adds outputs ref_count[15:0] and mrs_count[15:0], reset to 0.
  - Each increments on its cmd_valid issue and saturates at 16'hFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with all inputs 0 -> rw_idle=1, cmd_valid=0, maint_busy=0, err_proto=0.
- rw_proc=0, rw_busy=0, refresh_rdy pulse at cycle 10 -> PREA at cycle 11, REF at cycle 22, maint_busy falls at cycle 230.
- rw_busy=1 until cycle 40, mrs_update_rdy with cmd=14'h0A31 at cycle 5 -> PREA at cycle 42, then MRS with cmd_addr=14'h0A31 at cycle 53.
- refresh_rdy and mrs_update_rdy in the same cycle -> one PREA, REF, then MRS exactly T_RFC=208 clocks after REF.
- Second refresh_rdy while ref_pend=1 -> err_proto=1 and exactly one REF issued. Separately, rw_proc=1 during S_TRFC -> err_proto=1 and rw_req_ready=0.
- Assert reset_n=0 during S_TRP, then release -> no REF or MRS issued, state S_RUN, pend flags 0; with DDR_MAINT_STATS_EN, ref_count=0.

Source files
------------

// File: rtl/ddr_maint_responder.sv
// Maintenance responder: gates R/W traffic and issues PREA->REF / PREA->MRS with tRP/tRFC/tMOD spacing.
// Optional DDR_MAINT_STATS_EN adds saturating ref_count / mrs_count outputs.
module ddr_maint_responder #(
  parameter int MRS_WIDTH = 14,
  parameter int T_RP      = 11,
  parameter int T_RFC     = 208,
  parameter int T_MOD     = 24,
  parameter int CNT_W     = 9
) (
  input  logic                 clock_t,
  input  logic                 reset_n,
  input  logic                 rw_proc,
  input  logic                 rw_busy,
  input  logic                 rw_req_valid,
  output logic                 rw_req_ready,
  output logic                 rw_idle,
  input  logic                 refresh_rdy,
  input  logic                 mrs_update_rdy,
  input  logic [MRS_WIDTH-1:0] mrs_update_cmd,
  output logic                 cmd_valid,
  output logic [1:0]           cmd_code,
  output logic [MRS_WIDTH-1:0] cmd_addr,
  output logic                 maint_busy,
  output logic                 err_proto
`ifdef DDR_MAINT_STATS_EN
  ,
  output logic [15:0]          ref_count,
  output logic [15:0]          mrs_count
`endif
);

  typedef enum logic [2:0] {S_RUN, S_PREA, S_TRP, S_REF, S_TRFC, S_MRS, S_TMOD} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic                 ref_pend, mrs_pend, ref_clr, mrs_clr;
  logic [MRS_WIDTH-1:0] mrs_q;

  // Timers expire when the decremented value reaches zero, so a load of T-1
  // spaces the issue states exactly T clocks apart.
  logic expire;
  assign expire = (timer_q <= CNT_W'(1));

  assign maint_busy   = (state_q != S_RUN);
  assign rw_req_ready = rw_proc & ~maint_busy & (state_q == S_RUN);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cmd_valid = 1'b0;
    cmd_code  = 2'd0;
    cmd_addr  = '0;
    ref_clr   = 1'b0;
    mrs_clr   = 1'b0;
    case (state_q)
      S_RUN: begin
        // incoming pulses count too, so PREA follows a request by one clock
        if ((ref_pend | mrs_pend | refresh_rdy | mrs_update_rdy) & rw_idle) state_d = S_PREA;
      end
      S_PREA: begin
        cmd_valid = 1'b1;
        cmd_code  = 2'd1;
        timer_d   = CNT_W'(T_RP - 1);
        state_d   = S_TRP;
      end
      S_TRP: begin
        timer_d = timer_q - CNT_W'(1);
        if (expire) state_d = ref_pend ? S_REF : S_MRS;
      end
      S_REF: begin
        cmd_valid = 1'b1;
        cmd_code  = 2'd2;
        ref_clr   = 1'b1;
        timer_d   = CNT_W'(T_RFC - 1);
        state_d   = S_TRFC;
      end
      S_MRS: begin
        cmd_valid = 1'b1;
        cmd_code  = 2'd3;
        cmd_addr  = mrs_q;
        mrs_clr   = 1'b1;
        timer_d   = CNT_W'(T_MOD - 1);
        state_d   = S_TMOD;
      end
      S_TRFC: begin
        timer_d = timer_q - CNT_W'(1);
        if (expire) state_d = mrs_pend ? S_MRS : S_RUN;
      end
      S_TMOD: begin
        timer_d = timer_q - CNT_W'(1);
        if (expire) state_d = ref_pend ? S_REF : S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RUN;
      timer_q   <= '0;
      ref_pend  <= 1'b0;
      mrs_pend  <= 1'b0;
      mrs_q     <= '0;
      rw_idle   <= 1'b1;
      err_proto <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      // a new pulse beats a same-cycle clear
      ref_pend <= refresh_rdy | (ref_pend & ~ref_clr);
      mrs_pend <= mrs_update_rdy | (mrs_pend & ~mrs_clr);
      if (mrs_update_rdy) mrs_q <= mrs_update_cmd;
      rw_idle  <= ~rw_proc & ~rw_busy & ~(rw_req_valid & rw_req_ready);
      if ((refresh_rdy & ref_pend & ~ref_clr) | (mrs_update_rdy & mrs_pend & ~mrs_clr) |
          (rw_proc & maint_busy))
        err_proto <= 1'b1;
    end
  end

`ifdef DDR_MAINT_STATS_EN
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      ref_count <= '0;
      mrs_count <= '0;
    end else begin
      if (state_q == S_REF && ref_count != 16'hFFFF) ref_count <= ref_count + 16'd1;
      if (state_q == S_MRS && mrs_count != 16'hFFFF) mrs_count <= mrs_count + 16'd1;
    end
  end
`endif

endmodule
